tdm_distributor: RTL and testbench
==================================

TDM_DISTRIBUTOR -- requirements
Module: tdm_distributor

Interface
REQ-001 Parameter WIDTH, default 8, sets bits per channel word.
REQ-002 Parameter CHANNELS, default 8, sets the number of output channels (2..16).
REQ-003 Parameter DEPTH, default 4, sets input FIFO entries and SHALL be a power of two (2..16).
REQ-004 iClk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 iRst_n  in  1  asynchronous, active-low reset.
REQ-006 iData  in  WIDTH  word to distribute.
REQ-007 iSel  in  clog2(CHANNELS)  target channel in addressed mode.
REQ-008 iMode  in  1  0 = addressed, 1 = scan (round-robin).
REQ-009 iValid  in  1  iData/iSel/iMode valid this cycle.
REQ-010 oReady  out  1  FIFO can accept a word.
REQ-011 iEn  in  1  output stage may pop the FIFO this cycle.
REQ-012 iClr  in  1  synchronous clear of scan pointer and oErr.
REQ-013 oData  out  CHANNELS*WIDTH  per-channel held words; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-014 oStrobe  out  CHANNELS  one-cycle pulse on the channel updated this cycle.
REQ-015 oCount  out  clog2(DEPTH+1)  current FIFO occupancy.
REQ-016 oErr  out  1  sticky flag: an out-of-range iSel was dropped.

Function
REQ-017 A word SHALL be accepted on an edge where iValid and oReady are both 1.
REQ-018 oReady SHALL be 1 exactly when oCount < DEPTH, independent of any same-cycle pop.
REQ-019 Target channel is resolved at accept time: iSel if iMode=0; scan pointer if iMode=1.
REQ-020 Scan pointer advances by 1 per accepted scan-mode word and wraps from CHANNELS-1 to 0.
REQ-021 The scan pointer is unaffected by addressed-mode words and by changes of iMode.
REQ-022 Pop occurs on an edge where iEn=1 and oCount>0; at most one entry pops per cycle.
REQ-023 On a pop, the target channel's oData slice takes the word and its oStrobe bit is 1 for that cycle only.
REQ-024 Latency: a word accepted into an empty FIFO at edge k with iEn=1 SHALL appear on oData/oStrobe after edge k+1.
REQ-025 A simultaneous push and pop leaves oCount unchanged; a push into an empty FIFO does not pop in the same cycle.
REQ-026 A popped entry with channel >= CHANNELS produces no strobe and no data change, and sets oErr.
REQ-027 oStrobe SHALL be all-zero on cycles without a valid pop.
REQ-028 iClr=1 zeroes the scan pointer and oErr but not the FIFO or oData.
REQ-029 If iClr coincides with an accepted scan word, the word takes the old pointer and the pointer becomes 0.

Reset
REQ-030 While iRst_n=0, oData, oStrobe, oCount, oErr, the scan pointer and FIFO pointers SHALL be 0; oReady SHALL be 1.
REQ-031 Reset mid-operation SHALL discard all FIFO contents immediately, without completing any pending pop.

Configuration
REQ-032 Macro TDM_DISTRIBUTOR_CLEAR_EN: when defined, a channel's oData slice returns to 0 one cycle after its strobe unless re-strobed.
REQ-033 Without TDM_DISTRIBUTOR_CLEAR_EN, oData slices hold their last popped value indefinitely.

Structure
REQ-034 Package tdm_dist_pkg SHALL hold the MODE_ADDR/MODE_SCAN encodings and the FIFO entry layout: channel field plus data field.
REQ-035 FIFO storage and pointers SHALL be a sub-module sync_fifo (WIDTH, DEPTH parameters) instantiated once.

Verification
REQ-036 Addressed: iMode=0, push 8'hA5 to iSel=3, iEn=1 -> after 2 edges oData[31:24]=8'hA5, oStrobe=8'h08 for one cycle.
REQ-037 Scan: iMode=1, push 8'h01..8'h09 -> channels 0..7 then 0 get strobed in order; channel 0 ends holding 8'h09.
REQ-038 Full: iEn=0, push 5 words with DEPTH=4 -> oReady=0 after the 4th, oCount=4, 5th not accepted; iEn=1 drains all 4 in order.
REQ-039 Error: CHANNELS=6, push with iSel=7 -> no strobe, oErr=1 until iClr pulse.
REQ-040 Reset: assert iRst_n=0 with oCount=3 -> all outputs 0 and oReady=1 without waiting for a clock edge; the next push lands on scan channel 0.
REQ-041 With TDM_DISTRIBUTOR_CLEAR_EN: strobe channel 2 with 8'h3C -> slice is 8'h3C for one cycle, then 8'h00.

Source files
------------

// File: rtl/tdm_dist_pkg.sv
// Shared encodings for the TDM distributor: mode values, FIFO entry layout
// {channel, data} and the scan-pointer wrap helper.
package tdm_dist_pkg;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_SCAN = 1'b1
    } mode_e;

    // Channel field is sized for the largest legal channel count (16), so an
    // out-of-range iSel survives into the FIFO and is detected at pop time.
    localparam int CHAN_W = 4;

    typedef logic [CHAN_W-1:0] chan_t;

    // FIFO entry layout: channel field in the MSBs, data word in the LSBs.
    function automatic int entryWidth(input int dataWidth);
        return CHAN_W + dataWidth;
    endfunction

    function automatic chan_t nextScan(input chan_t ptr, input int channels);
        if (int'(ptr) >= channels - 1) begin
            return '0;
        end
        return ptr + chan_t'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head entry is presented
// combinationally. Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         iClk,
    input  logic                         iRst_n,
    input  logic                         iPush,
    input  logic                         iPop,
    input  logic [WIDTH-1:0]             iData,
    output logic [WIDTH-1:0]             oData,
    output logic [$clog2(DEPTH+1)-1:0]   oCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPush = iPush && (oCount != CNT_W'(DEPTH));
    assign doPop  = iPop && (oCount != '0);
    assign oData  = mem[rdPtr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge iClk) begin
        if (doPush) begin
            mem[wrPtr] <= iData;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oCount <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   oCount <= oCount + CNT_W'(1);
                2'b01:   oCount <= oCount - CNT_W'(1);
                default: oCount <= oCount;
            endcase
        end
    end

endmodule

// File: rtl/tdm_distributor.sv
// Buffers words in a FIFO and distributes them to per-channel held outputs,
// addressed or round-robin. Optional macro TDM_DISTRIBUTOR_CLEAR_EN makes each
// slice return to zero one cycle after its strobe.
module tdm_distributor
    import tdm_dist_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 4
) (
    input  logic                         iClk,
    input  logic                         iRst_n,
    input  logic [WIDTH-1:0]             iData,
    input  logic [$clog2(CHANNELS)-1:0]  iSel,
    input  logic                         iMode,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic                         iEn,
    input  logic                         iClr,
    output logic [CHANNELS*WIDTH-1:0]    oData,
    output logic [CHANNELS-1:0]          oStrobe,
    output logic [$clog2(DEPTH+1)-1:0]   oCount,
    output logic                         oErr
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = entryWidth(WIDTH);

    logic                      accept;
    logic                      pop;
    logic                      popHit;
    chan_t                     scanPtr;
    chan_t                     pushChan;
    chan_t                     popChan;
    logic [WIDTH-1:0]          popData;
    logic [ENTRY_W-1:0]        pushEntry;
    logic [ENTRY_W-1:0]        popEntry;
    logic [CHANNELS-1:0]       strobeNext;
    logic [CHANNELS*WIDTH-1:0] dataNext;

    // Ready depends on stored occupancy only, never on a same-cycle pop.
    assign oReady    = (oCount < CNT_W'(DEPTH));
    assign accept    = iValid && oReady;
    assign pushChan  = (iMode == MODE_SCAN) ? scanPtr : chan_t'(iSel);
    assign pushEntry = {pushChan, iData};

    assign pop              = iEn && (oCount != '0);
    assign {popChan, popData} = popEntry;
    assign popHit           = pop && (int'(popChan) < CHANNELS);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iPush  (accept),
        .iPop   (pop),
        .iData  (pushEntry),
        .oData  (popEntry),
        .oCount (oCount)
    );

    // A scan word accepted together with iClr still uses the old pointer.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            scanPtr <= '0;
        end else if (iClr) begin
            scanPtr <= '0;
        end else if (accept && (iMode == MODE_SCAN)) begin
            scanPtr <= nextScan(scanPtr, CHANNELS);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oErr <= 1'b0;
        end else if (iClr) begin
            oErr <= 1'b0;
        end else if (pop && !popHit) begin
            oErr <= 1'b1;
        end
    end

    always_comb begin
        strobeNext = '0;
        dataNext   = oData;
        for (int n = 0; n < CHANNELS; n++) begin
`ifdef TDM_DISTRIBUTOR_CLEAR_EN
            if (oStrobe[n]) begin
                dataNext[n*WIDTH +: WIDTH] = '0;
            end
`endif
            if (popHit && (popChan == chan_t'(n))) begin
                strobeNext[n]              = 1'b1;
                dataNext[n*WIDTH +: WIDTH] = popData;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oData   <= '0;
            oStrobe <= '0;
        end else begin
            oData   <= dataNext;
            oStrobe <= strobeNext;
        end
    end

endmodule

// File: tb/tb_tdm_distributor.sv
// Scoreboard bench for tdm_distributor: default 8-channel instance plus a
// 6-channel instance for out-of-range select handling.
module tb_tdm_distributor;

    logic        iClk;
    logic        iRst_n;
    logic [7:0]  iData;
    logic [2:0]  iSel;
    logic        iMode;
    logic        iValid;
    logic        oReady;
    logic        iEn;
    logic        iClr;
    logic [63:0] oData;
    logic [7:0]  oStrobe;
    logic [2:0]  oCount;
    logic        oErr;

    logic [7:0]  eData;
    logic [2:0]  eSel;
    logic        eMode;
    logic        eValid;
    logic        eReady;
    logic        eEn;
    logic        eClr;
    logic [47:0] eDataOut;
    logic [5:0]  eStrobe;
    logic [2:0]  eCount;
    logic        eErr;

    int          asserts = 0;
    int          fails   = 0;
    logic [11:0] expQ[$];
    logic [3:0]  modelPtr;
    logic [11:0] monEntry;
    logic [7:0]  monStb;
    logic [7:0]  monData;
    logic        sawStb;

    tdm_distributor #(.WIDTH(8), .CHANNELS(8), .DEPTH(4)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iSel(iSel), .iMode(iMode),
        .iValid(iValid), .oReady(oReady), .iEn(iEn), .iClr(iClr), .oData(oData),
        .oStrobe(oStrobe), .oCount(oCount), .oErr(oErr)
    );

    tdm_distributor #(.WIDTH(8), .CHANNELS(6), .DEPTH(4)) dut6 (
        .iClk(iClk), .iRst_n(iRst_n), .iData(eData), .iSel(eSel), .iMode(eMode),
        .iValid(eValid), .oReady(eReady), .iEn(eEn), .iClr(eClr), .oData(eDataOut),
        .oStrobe(eStrobe), .oCount(eCount), .oErr(eErr)
    );

    // Clock and watchdog
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] heldVal(input logic [7:0] v);
`ifdef TDM_DISTRIBUTOR_CLEAR_EN
        return 8'h00;
`else
        return v;
`endif
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: one word offered for one edge; accepted if oReady was high.
    task automatic pushWord(input logic mode, input logic [2:0] sel, input logic [7:0] d,
                            input logic clr);
        logic       acc;
        logic [3:0] ch;
        iMode  = mode;
        iSel   = sel;
        iData  = d;
        iClr   = clr;
        iValid = 1'b1;
        acc    = oReady;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iClr   = 1'b0;
        if (acc) begin
            ch = mode ? modelPtr : {1'b0, sel};
            expQ.push_back({ch, d});
        end
        if (clr) modelPtr = 4'd0;
        else if (acc && mode) modelPtr = (modelPtr == 4'd7) ? 4'd0 : modelPtr + 4'd1;
    endtask

    task automatic waitEmpty(input string name);
        int n = 0;
        while ((expQ.size() != 0 || oCount != 3'd0) && n < 40) begin
            @(negedge iClk);
            #1;
            n++;
        end
        asserts++;
        if (expQ.size() != 0 || oCount != 3'd0) begin
            fails++;
            $display("FAIL %s_drain: got %0d pending, %0d in fifo, required 0", name,
                     expQ.size(), oCount);
        end
    endtask

    // Monitor: every strobe must match the oldest expected {channel, data}.
    always @(negedge iClk) begin
        if (iRst_n && oStrobe != 8'h00) begin
            asserts++;
            if (expQ.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: got strobe %0h with none pending", oStrobe);
            end else begin
                monEntry = expQ.pop_front();
                monStb   = 8'b1 << monEntry[10:8];
                monData  = oData[int'(monEntry[10:8])*8 +: 8];
                if (oStrobe !== monStb || monData !== monEntry[7:0]) begin
                    fails++;
                    $display("FAIL monitor_pop: got strobe %0h data %0h, required strobe %0h data %0h",
                             oStrobe, monData, monStb, monEntry[7:0]);
                end
            end
        end
    end

    initial begin
        iRst_n = 1'b0;
        {iData, iSel, iMode, iValid, iEn, iClr} = '0;
        {eData, eSel, eMode, eValid, eEn, eClr} = '0;
        modelPtr = 4'd0;

        repeat (3) @(negedge iClk);
        checkVal("rst_count", oCount, 0);
        checkVal("rst_ready", oReady, 1);
        checkVal("rst_data", oData, 0);
        checkVal("rst_strobe", oStrobe, 0);
        checkVal("rst_err", oErr, 0);
        checkVal("rst_ready6", eReady, 1);
        iRst_n = 1'b1;
        @(posedge iClk);
        #1;

        // Addressed word, latency and one-cycle strobe
        iEn = 1'b1;
        pushWord(1'b0, 3'd3, 8'hA5, 1'b0);
        @(negedge iClk);
        checkVal("addr_lat_strobe0", oStrobe, 8'h00);
        checkVal("addr_lat_count1", oCount, 1);
        @(negedge iClk);
        checkVal("addr_strobe", oStrobe, 8'h08);
        checkVal("addr_data", oData[31:24], 8'hA5);
        @(negedge iClk);
        checkVal("addr_strobe_once", oStrobe, 8'h00);

        // Round-robin scan across all channels plus wrap
        for (int i = 1; i <= 9; i++) pushWord(1'b1, 3'd0, 8'(i), 1'b0);
        waitEmpty("scan");
        checkVal("scan_ch0", oData[7:0], 8'h09);
        checkVal("scan_ch1", oData[15:8], heldVal(8'h02));
        checkVal("scan_ch7", oData[63:56], heldVal(8'h08));

        // Full FIFO, rejected 5th word, ready ignores same-cycle pop
        iEn = 1'b0;
        pushWord(1'b0, 3'd1, 8'h11, 1'b0);
        pushWord(1'b0, 3'd2, 8'h22, 1'b0);
        pushWord(1'b0, 3'd4, 8'h33, 1'b0);
        pushWord(1'b0, 3'd5, 8'h44, 1'b0);
        checkVal("full_ready", oReady, 0);
        checkVal("full_count", oCount, 4);
        pushWord(1'b0, 3'd6, 8'h55, 1'b0);
        checkVal("full_reject_count", oCount, 4);
        iEn = 1'b1;
        #1;
        checkVal("full_ready_with_pop", oReady, 0);
        @(posedge iClk);
        #1;
        checkVal("full_pop_count", oCount, 3);
        pushWord(1'b0, 3'd6, 8'h66, 1'b0);
        checkVal("push_pop_count", oCount, 3);
        waitEmpty("full");

        // Clear coinciding with a scan word; addressed words leave pointer alone
        pushWord(1'b1, 3'd0, 8'h81, 1'b1);
        pushWord(1'b1, 3'd0, 8'h82, 1'b0);
        pushWord(1'b0, 3'd5, 8'h83, 1'b0);
        pushWord(1'b1, 3'd0, 8'h84, 1'b0);
        waitEmpty("clr_scan");
        checkVal("clr_scan_ch1", oData[15:8], 8'h84);
        checkVal("clr_scan_err", oErr, 0);

        // Out-of-range select on the 6-channel instance
        eEn    = 1'b1;
        eMode  = 1'b0;
        eSel   = 3'd7;
        eData  = 8'hEE;
        eValid = 1'b1;
        @(posedge iClk);
        #1;
        eValid = 1'b0;
        sawStb = 1'b0;
        repeat (3) begin
            @(negedge iClk);
            if (eStrobe != 6'h00) sawStb = 1'b1;
        end
        checkVal("err_no_strobe", sawStb, 0);
        checkVal("err_no_data", eDataOut, 0);
        checkVal("err_flag", eErr, 1);
        checkVal("err_count", eCount, 0);
        eSel   = 3'd5;
        eData  = 8'h5A;
        eValid = 1'b1;
        @(posedge iClk);
        #1;
        eValid = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        checkVal("err_valid_strobe", eStrobe, 6'h20);
        checkVal("err_valid_data", eDataOut[47:40], 8'h5A);
        checkVal("err_sticky", eErr, 1);
        eClr = 1'b1;
        @(posedge iClk);
        #1;
        eClr = 1'b0;
        checkVal("err_cleared", eErr, 0);

        // Asynchronous reset with three words queued
        iEn = 1'b0;
        pushWord(1'b1, 3'd0, 8'hC1, 1'b0);
        pushWord(1'b1, 3'd0, 8'hC2, 1'b0);
        pushWord(1'b1, 3'd0, 8'hC3, 1'b0);
        checkVal("pre_reset_count", oCount, 3);
        #2;
        iRst_n = 1'b0;
        #1;
        checkVal("async_rst_count", oCount, 0);
        checkVal("async_rst_ready", oReady, 1);
        checkVal("async_rst_data", oData, 0);
        checkVal("async_rst_strobe", oStrobe, 0);
        checkVal("async_rst_err", oErr, 0);
        expQ.delete();
        modelPtr = 4'd0;
        @(negedge iClk);
        iRst_n = 1'b1;
        iEn = 1'b1;
        pushWord(1'b1, 3'd0, 8'h77, 1'b0);
        waitEmpty("post_reset");
        checkVal("post_reset_ch0", oData[7:0], 8'h77);

        // Held value versus clear-after-strobe
        pushWord(1'b0, 3'd2, 8'h3C, 1'b0);
        @(negedge iClk);
        @(negedge iClk);
        checkVal("hold_strobe", oStrobe, 8'h04);
        checkVal("hold_first", oData[23:16], 8'h3C);
        @(negedge iClk);
        checkVal("hold_next", oData[23:16], heldVal(8'h3C));
        repeat (3) @(negedge iClk);
        checkVal("hold_later", oData[23:16], heldVal(8'h3C));

        checkVal("queue_empty_at_end", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
